// File: rtl/conv_fprop_arb_pkg.sv
// Shared definitions for the conv_fprop multiplier-sharing arbiter.
// Holds the default operand/product widths, a constant clog2 helper used to
// size requester indices, and the packed response record {id, data}.
package conv_fprop_arb_pkg;

    localparam int ARB_NUM_REQ = 4;
    localparam int ARB_DATA_W  = 10;
    localparam int ARB_DOUT_W  = 10;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int ARB_ID_W = clog2(ARB_NUM_REQ);

    typedef struct packed {
        logic [ARB_ID_W-1:0]   id;
        logic [ARB_DOUT_W-1:0] data;
    } arb_rsp_t;

endpackage

// File: rtl/conv_fprop_rr_pick.sv
// Combinational rotate-priority encoder.
// Scans requesters starting one past last_grant_i (modulo NUM_REQ) and picks
// the first one with its request bit set, but only while en_i is high.
// Ports:
//   req_i        request vector
//   last_grant_i index of the most recently granted requester
//   en_i         grant enable (output slot free)
//   gnt_oh_o     one-hot grant, all-zero when nothing is granted
//   gnt_idx_o    index of the granted requester (0 when none)
//   any_gnt_o    a grant is present this cycle
module conv_fprop_rr_pick
    import conv_fprop_arb_pkg::*;
#(
    parameter int NUM_REQ = ARB_NUM_REQ,
    parameter int ID_W    = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_grant_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_oh_o,
    output logic [ID_W-1:0]    gnt_idx_o,
    output logic               any_gnt_o
);

    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        any_gnt_o = 1'b0;
        if (en_i) begin
            // k is the distance from the last grant; the first hit wins.
            for (int k = 1; k <= NUM_REQ; k++) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!any_gnt_o && req_i[i] &&
                        (i == ((int'(last_grant_i) + k) % NUM_REQ))) begin
                        any_gnt_o   = 1'b1;
                        gnt_idx_o   = ID_W'(i);
                        gnt_oh_o[i] = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/conv_fprop_mul_share_arb.sv
// Round-robin arbiter time-sharing one external signed multiplier among
// NUM_REQ requesters. The granted requester's operands drive the multiplier
// combinationally; its product is captured into a one-entry response
// register tagged with the requester index.
// Ports:
//   ap_clk, ap_rst_n        clock, synchronous active-low reset
//   req_valid/req_ready     per-requester handshake (req_ready one-hot or 0)
//   req_a/req_b             packed operands, requester i at [i*DATA_W +: DATA_W]
//   mul_din0/mul_din1       operands to the shared multiplier (0 when idle)
//   mul_dout                same-cycle product from the shared multiplier
//   rsp_valid/rsp_ready     response handshake
//   rsp_id/rsp_data         owner index and registered product
//   ops_done                accepted-operation counter, wraps at 16 bits
module conv_fprop_mul_share_arb
    import conv_fprop_arb_pkg::*;
#(
    parameter  int NUM_REQ = ARB_NUM_REQ,
    parameter  int DATA_W  = ARB_DATA_W,
    parameter  int DOUT_W  = ARB_DOUT_W,
    localparam int ID_W    = clog2(NUM_REQ)
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   req_a,
    input  logic [NUM_REQ*DATA_W-1:0]   req_b,
    output logic signed [DATA_W-1:0]    mul_din0,
    output logic signed [DATA_W-1:0]    mul_din1,
    input  logic signed [DOUT_W-1:0]    mul_dout,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [ID_W-1:0]             rsp_id,
    output logic signed [DOUT_W-1:0]    rsp_data,
    output logic [15:0]                 ops_done
);

    logic                     rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]          rsp_id_q, rsp_id_d;
    logic signed [DOUT_W-1:0] rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]          last_grant_q, last_grant_d;
    logic [15:0]              ops_done_q, ops_done_d;

    logic                     can_issue;
    logic [NUM_REQ-1:0]       gnt_oh;
    logic [ID_W-1:0]          gnt_idx;
    logic                     any_gnt;

    // The output slot accepts a new product when empty or draining this cycle.
    assign can_issue = !rsp_valid_q || rsp_ready;

    conv_fprop_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .en_i         (can_issue),
        .gnt_oh_o     (gnt_oh),
        .gnt_idx_o    (gnt_idx),
        .any_gnt_o    (any_gnt)
    );

    assign req_ready = gnt_oh;

    // Operand mux: one-hot select, zero when idle to keep the multiplier quiet.
    always_comb begin
        mul_din0 = '0;
        mul_din1 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_oh[i]) begin
                mul_din0 = req_a[i*DATA_W +: DATA_W];
                mul_din1 = req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        last_grant_d = last_grant_q;
        ops_done_d   = ops_done_q;
        if (any_gnt) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = gnt_idx;
            rsp_data_d   = mul_dout;
            last_grant_d = gnt_idx;
            ops_done_d   = ops_done_q + 16'd1;
        end else if (rsp_ready) begin
            rsp_valid_d  = 1'b0;
        end
    end

    // Response register stage
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            ops_done_q   <= '0;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            last_grant_q <= last_grant_d;
            ops_done_q   <= ops_done_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_conv_fprop_mul_share_arb.sv
// Self-checking bench for conv_fprop_mul_share_arb: directed vector table,
// hand-written reset sequence, and a randomized fairness/scoreboard run.
module tb_conv_fprop_mul_share_arb;
    import conv_fprop_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 10;
    localparam int OW = 10;

    logic            ap_clk;
    logic            ap_rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_a;
    logic [N*DW-1:0] req_b;
    logic [DW-1:0]   mul_din0;
    logic [DW-1:0]   mul_din1;
    logic [OW-1:0]   mul_dout;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [OW-1:0]   rsp_data;
    logic [15:0]     ops_done;

    int checks   = 0;
    int failures = 0;

    conv_fprop_mul_share_arb #(.NUM_REQ(N), .DATA_W(DW), .DOUT_W(OW)) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_din0  (mul_din0),
        .mul_din1  (mul_din1),
        .mul_dout  (mul_dout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .ops_done  (ops_done)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    // External shared multiplier: low OW bits of the signed product.
    function automatic logic [OW-1:0] mulw(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic signed [2*DW-1:0] p;
        p = $signed(a) * $signed(b);
        return p[OW-1:0];
    endfunction

    assign mul_dout = mulw(mul_din0, mul_din1);

    function automatic logic [9:0] s10(input int x);
        return x[9:0];
    endfunction

    function automatic logic [39:0] a4(input int v0, input int v1, input int v2, input int v3);
        return {s10(v3), s10(v2), s10(v1), s10(v0)};
    endfunction

    typedef struct packed {
        logic [3:0]  vld;
        logic        rdy;
        logic [39:0] a;
        logic [39:0] b;
        logic [3:0]  exp_ready;
        logic [9:0]  exp_din0;
        logic [9:0]  exp_din1;
        logic        exp_rv;
        logic [1:0]  exp_id;
        logic [9:0]  exp_data;
        logic [15:0] exp_ops;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] vld, input logic rdy,
                                input logic [39:0] a, input logic [39:0] b,
                                input logic [3:0] er, input int d0, input int d1,
                                input logic rv, input logic [1:0] id,
                                input logic [9:0] data, input logic [15:0] ops);
        vec_t v;
        v.vld = vld; v.rdy = rdy; v.a = a; v.b = b;
        v.exp_ready = er; v.exp_din0 = s10(d0); v.exp_din1 = s10(d1);
        v.exp_rv = rv; v.exp_id = id; v.exp_data = data; v.exp_ops = ops;
        return v;
    endfunction

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic chk_regs(input string tag, input logic rv, input logic [1:0] id,
                            input logic [9:0] data, input logic [15:0] ops);
        chk({tag, ".rsp_valid"}, 40'(rsp_valid), 40'(rv));
        chk({tag, ".rsp_id"},    40'(rsp_id),    40'(id));
        chk({tag, ".rsp_data"},  40'(rsp_data),  40'(data));
        chk({tag, ".ops_done"},  40'(ops_done),  40'(ops));
    endtask

    // Random-phase model state
    logic [N-1:0]  pend;
    logic [DW-1:0] ra [N];
    logic [DW-1:0] rb [N];
    int            ptr;
    logic          rv_m;
    int            wait2;
    int            resp_cnt;
    arb_rsp_t      sb [$];
    logic          hold_en = 1'b0;

    // Requester hold rule: a pending request keeps valid and operands stable.
    logic [N-1:0]    pv, pr;
    logic [N*DW-1:0] pa, pb;
    always @(posedge ap_clk) begin
        if (hold_en && ap_rst_n) begin
            for (int i = 0; i < N; i++) begin
                if (pv[i] && !pr[i]) begin
                    checks <= checks + 1;
                    if (!req_valid[i] || req_a[i*DW +: DW] != pa[i*DW +: DW] ||
                        req_b[i*DW +: DW] != pb[i*DW +: DW]) begin
                        failures <= failures + 1;
                        $display("FAIL hold_rule req%0d: valid %0b expected 1", i, req_valid[i]);
                    end
                end
            end
        end
        pv <= req_valid;
        pr <= req_ready;
        pa <= req_a;
        pb <= req_b;
    end

    function automatic int rr_exp(input logic [N-1:0] v, input int p);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (p + k) % N;
            if (v[2'(i)]) return i;
        end
        return -1;
    endfunction

    task automatic drive_pend();
        req_valid = pend;
        for (int i = 0; i < N; i++) begin
            req_a[i*DW +: DW] = ra[i];
            req_b[i*DW +: DW] = rb[i];
        end
    endtask

    task automatic rand_cycle(input bit drain);
        int g;
        logic [N-1:0] er;
        arb_rsp_t e;
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && !drain && (i == 2 || $urandom_range(0, 1) == 1)) begin
                pend[i] = 1'b1;
                ra[i] = DW'($urandom);
                rb[i] = DW'($urandom);
                if (i == 2) wait2 = 0;
            end
        end
        rsp_ready = drain ? 1'b1 : 1'($urandom_range(0, 1));
        drive_pend();
        #1;
        g  = (!rv_m || rsp_ready) ? rr_exp(pend, ptr) : -1;
        er = (g >= 0) ? N'(1 << g) : '0;
        chk("rand.req_ready", 40'(req_ready), 40'(er));
        chk("rand.rsp_valid", 40'(rsp_valid), 40'(rv_m));
        if (rv_m && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("rand.sb_nonempty", 40'(0), 40'(1));
            end else begin
                e = sb.pop_front();
                chk("rand.rsp_id",   40'(rsp_id),   40'(e.id));
                chk("rand.rsp_data", 40'(rsp_data), 40'(e.data));
            end
            resp_cnt++;
        end
        if (g >= 0) begin
            e.id   = 2'(g);
            e.data = mulw(ra[g], rb[g]);
            sb.push_back(e);
            if (g == 2) begin
                chk("rand.req2_wait", 40'(wait2 > N - 1), 40'(0));
            end else if (pend[2]) begin
                wait2++;
            end
            ptr     = g;
            pend[g] = 1'b0;
            rv_m    = 1'b1;
        end else if (rsp_ready) begin
            rv_m = 1'b0;
        end
        tick();
    endtask

    vec_t tbl [15];

    initial begin
        tbl[0]  = mk(4'b0001, 1'b1, a4(3,0,0,0),    a4(-4,0,0,0),   4'b0001, 3,   -4,   1'b1, 2'd0, 10'h3F4, 16'd1);
        tbl[1]  = mk(4'b0001, 1'b1, a4(511,0,0,0),  a4(511,0,0,0),  4'b0001, 511, 511,  1'b1, 2'd0, 10'h001, 16'd2);
        tbl[2]  = mk(4'b0001, 1'b1, a4(-512,0,0,0), a4(-512,0,0,0), 4'b0001, -512,-512, 1'b1, 2'd0, 10'h000, 16'd3);
        tbl[3]  = mk(4'b0000, 1'b1, a4(0,0,0,0),    a4(0,0,0,0),    4'b0000, 0,   0,    1'b0, 2'd0, 10'h000, 16'd3);
        tbl[4]  = mk(4'b1111, 1'b1, a4(1,2,3,4),    a4(5,6,7,8),    4'b0010, 2,   6,    1'b1, 2'd1, 10'h00C, 16'd4);
        tbl[5]  = mk(4'b1111, 1'b1, a4(1,2,3,4),    a4(5,6,7,8),    4'b0100, 3,   7,    1'b1, 2'd2, 10'h015, 16'd5);
        tbl[6]  = mk(4'b1111, 1'b1, a4(1,2,3,4),    a4(5,6,7,8),    4'b1000, 4,   8,    1'b1, 2'd3, 10'h020, 16'd6);
        tbl[7]  = mk(4'b1111, 1'b1, a4(1,2,3,4),    a4(5,6,7,8),    4'b0001, 1,   5,    1'b1, 2'd0, 10'h005, 16'd7);
        tbl[8]  = mk(4'b0110, 1'b0, a4(0,-3,100,0), a4(0,7,-6,0),   4'b0000, 0,   0,    1'b1, 2'd0, 10'h005, 16'd7);
        tbl[9]  = mk(4'b0110, 1'b0, a4(0,-3,100,0), a4(0,7,-6,0),   4'b0000, 0,   0,    1'b1, 2'd0, 10'h005, 16'd7);
        tbl[10] = mk(4'b0110, 1'b0, a4(0,-3,100,0), a4(0,7,-6,0),   4'b0000, 0,   0,    1'b1, 2'd0, 10'h005, 16'd7);
        tbl[11] = mk(4'b0110, 1'b1, a4(0,-3,100,0), a4(0,7,-6,0),   4'b0010, -3,  7,    1'b1, 2'd1, 10'h3EB, 16'd8);
        tbl[12] = mk(4'b0100, 1'b1, a4(0,-3,100,0), a4(0,7,-6,0),   4'b0100, 100, -6,   1'b1, 2'd2, 10'h1A8, 16'd9);
        tbl[13] = mk(4'b0000, 1'b0, a4(0,0,0,0),    a4(0,0,0,0),    4'b0000, 0,   0,    1'b1, 2'd2, 10'h1A8, 16'd9);
        tbl[14] = mk(4'b0000, 1'b1, a4(0,0,0,0),    a4(0,0,0,0),    4'b0000, 0,   0,    1'b0, 2'd2, 10'h1A8, 16'd9);

        // Reset state
        ap_rst_n  = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        chk_regs("reset", 1'b0, 2'd0, 10'h000, 16'd0);
        ap_rst_n = 1'b1;
        #1;
        chk("reset.req_ready", 40'(req_ready), 40'(0));
        tick();

        // Directed vector table
        for (int n = 0; n < 15; n++) begin
            req_valid = tbl[n].vld;
            req_a     = tbl[n].a;
            req_b     = tbl[n].b;
            rsp_ready = tbl[n].rdy;
            #1;
            chk($sformatf("v%0d.req_ready", n), 40'(req_ready), 40'(tbl[n].exp_ready));
            chk($sformatf("v%0d.mul_din0", n),  40'(mul_din0),  40'(tbl[n].exp_din0));
            chk($sformatf("v%0d.mul_din1", n),  40'(mul_din1),  40'(tbl[n].exp_din1));
            tick();
            chk_regs($sformatf("v%0d", n), tbl[n].exp_rv, tbl[n].exp_id, tbl[n].exp_data, tbl[n].exp_ops);
        end

        // Reset while a response is pending with ops_done=7
        ap_rst_n = 1'b0;
        tick();
        ap_rst_n  = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        req_a     = a4(1,0,0,0);
        req_b     = a4(1,0,0,0);
        for (int n = 0; n < 7; n++) tick();
        chk_regs("pre_rst", 1'b1, 2'd0, 10'h001, 16'd7);
        ap_rst_n  = 1'b0;
        req_valid = '0;
        tick();
        chk_regs("mid_rst", 1'b0, 2'd0, 10'h000, 16'd0);
        ap_rst_n  = 1'b1;
        req_valid = 4'b1001;
        req_a     = a4(4,0,0,2);
        req_b     = a4(5,0,0,3);
        #1;
        chk("post_rst.first_grant", 40'(req_ready), 40'(4'b0001));
        tick();
        chk_regs("post_rst.r0", 1'b1, 2'd0, 10'h014, 16'd1);
        req_valid = 4'b1000;
        #1;
        chk("post_rst.second_grant", 40'(req_ready), 40'(4'b1000));
        tick();
        chk_regs("post_rst.r3", 1'b1, 2'd3, 10'h006, 16'd2);

        // Randomized fairness run with scoreboard
        ap_rst_n  = 1'b0;
        req_valid = '0;
        tick();
        ap_rst_n = 1'b1;
        pend     = '0;
        for (int i = 0; i < N; i++) begin
            ra[i] = '0;
            rb[i] = '0;
        end
        ptr      = N - 1;
        rv_m     = 1'b0;
        wait2    = 0;
        resp_cnt = 0;
        hold_en  = 1'b1;
        for (int n = 0; n < 1000; n++) rand_cycle(1'b0);
        for (int n = 0; n < 8; n++) rand_cycle(1'b1);
        hold_en = 1'b0;
        chk("rand.sb_empty", 40'(sb.size()), 40'(0));
        chk("rand.ops_done", 40'(ops_done), 40'(resp_cnt % 65536));
        chk("rand.final_rsp_valid", 40'(rsp_valid), 40'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_fprop_mul_share_arb.md
Name: conv_fprop_mul_share_arb

Overview:
Round-robin arbiter that time-shares one signed NUM-bit multiplier among NUM_REQ requesters in the conv_fprop datapath.
- Each requester presents an operand pair with a valid/ready handshake.
- The arbiter drives the shared multiplier's inputs from the granted requester and registers the product.
- It returns the product with the requester index on one response channel that supports backpressure.
- It sits between the conv_fprop loop-body producers and the single shared multiplier instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 10, signed operand width
DOUT_W, 10, product width; low DOUT_W bits of the full signed product
ID_W, clog2(NUM_REQ), localparam, requester index width

Ports:
ap_clk  in  1  clock
ap_rst_n  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle
req_a  in  NUM_REQ*DATA_W  packed operand A; requester i at bits [i*DATA_W +: DATA_W]
req_b  in  NUM_REQ*DATA_W  packed operand B; same packing
mul_din0  out  DATA_W  to shared multiplier din0
mul_din1  out  DATA_W  to shared multiplier din1
mul_dout  in  DOUT_W  from shared multiplier; combinational, same-cycle product
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  ID_W  index of requester that owns rsp_data
rsp_data  out  DOUT_W  registered product
ops_done  out  16  count of accepted operations; wraps at 0xFFFF -> 0

Behaviour:
- Clock and reset: one clock, ap_clk. Reset is synchronous and active-low on ap_rst_n.
- Reset values: rsp_valid=0, rsp_id=0, rsp_data=0, ops_done=0, last_grant=NUM_REQ-1. With that last_grant, requester 0 has first priority after reset.
- Slot free: can_issue = !rsp_valid || rsp_ready. This is a one-entry output register with pass-through drain.
- Grant (combinational):
  - If can_issue, grant the first i with req_valid[i]=1, scanning last_grant+1, last_grant+2, ... modulo NUM_REQ.
  - req_ready = one-hot(grant). It is all-zero if no valid requester or !can_issue.
  - req_ready must not depend on rsp_valid alone, only on can_issue.
- Multiplier drive: mul_din0/mul_din1 = req_a/req_b of the granted requester. They are 0 when there is no grant, which avoids needless toggling.
- Accept edge (grant present):
  - rsp_data <= mul_dout.
  - rsp_id <= grant.
  - rsp_valid <= 1.
  - last_grant <= grant.
  - ops_done <= ops_done+1.
- Latency: exactly 1 cycle from accept to rsp_valid. Throughput is 1 op/cycle while rsp_ready=1.
- Drain without new grant: if rsp_valid && rsp_ready && no grant, then rsp_valid <= 0.
- Backpressure: while rsp_valid && !rsp_ready, rsp_data and rsp_id hold stable, all req_ready=0, and last_grant is unchanged.
- Arithmetic: the product is the low DOUT_W bits of $signed(a)*$signed(b), as two's-complement wrap. The arbiter does no saturation.
- Fairness: a continuously valid requester is granted within NUM_REQ accepted operations. last_grant moves only on an accepted grant.
- Requester rules: once req_valid rises, req_a/req_b/req_valid must hold until req_ready. The bench asserts this; the arbiter does not check it.
- Reset mid-operation: a pending response is discarded (rsp_valid=0), the pointer returns to NUM_REQ-1, and ops_done is cleared.

Decomposition:
- Shared package conv_fprop_arb_pkg holds:
  - DATA_W/DOUT_W defaults.
  - The ID_W function clog2.
  - A packed response struct {id, data}.
- One natural sub-module: conv_fprop_rr_pick, a combinational rotate-priority-encoder. Its inputs are req vector, last_grant and enable; its outputs are one-hot grant, grant index and any_grant.
- The multiplier stays outside the arbiter; the top level wires mul_din0/mul_din1/mul_dout to it.

Test Plan:
- Single op, rsp_ready=1: req0 with a=3, b=-4 -> 1 cycle later rsp_valid=1, rsp_id=0, rsp_data=10'h3F4, ops_done=1.
- Wrap arithmetic: a=511, b=511 -> rsp_data=10'h001. a=-512, b=-512 -> rsp_data=10'h000.
- Round-robin: all 4 req_valid held high, 5 ops -> grant order 0,1,2,3,0, one grant per cycle, rsp_id sequence matches one cycle later.
- Backpressure: rsp_ready=0 for 3 cycles with req1 and req2 valid -> req_ready stays 0 and rsp_data/rsp_id stay stable. rsp_ready=1 then drains, and req1 is granted in that same cycle.
- Reset mid-op: assert ap_rst_n=0 while rsp_valid=1 and ops_done=7 -> next cycle rsp_valid=0, ops_done=0. After release with req3 and req0 valid, req0 is granted first.
- Starvation check: req2 always valid, others random for 1000 cycles with random rsp_ready -> req2 never waits more than 4 accepted ops, and the total of ops_done matches the response count mod 2^16.
